hazard_dest_scheduler: RTL and testbench
========================================

Name: hazard_dest_scheduler

Overview:
- Tracks the destination register of every in-flight instruction from decode to writeback.
- Selects the destination per instruction as rd or rt, the same rule as the decode-stage destination mux, and pipes it through EX/MEM/WB tracking slots.
- Issues load-use stalls to the fetch/decode registers and registered forwarding selects to the EX-stage operand muxes.
- Sits beside the ID/EX pipeline register; it is the block that sequences the destination-register datapath.

Parameters:
- BITS_REGS, 5, register index width.
- STAT_BITS, 32, width of the stall counter (used only with the optional feature).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous reset, active-high.
- i_halt  in  1  debug freeze; all state holds.
- i_valid  in  1  ID stage holds a real instruction.
- i_flush  in  1  kill the ID instruction (taken branch/jump).
- i_rs  in  BITS_REGS  ID source register rs.
- i_rt  in  BITS_REGS  ID source register rt / alternate destination.
- i_rd  in  BITS_REGS  ID destination register rd.
- i_uses_rs  in  1  ID instruction reads rs.
- i_uses_rt  in  1  ID instruction reads rt.
- i_ctl_reg_dst_rd  in  1  1: destination = rd; 0: destination = rt.
- i_ctl_reg_write  in  1  ID instruction writes the register file.
- i_ctl_mem_read  in  1  ID instruction is a load.
- o_stall  out  1  hold PC and IF/ID; bubble into EX.
- o_fwd_a  out  2  EX operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB.
- o_fwd_b  out  2  EX operand B source, same encoding.
- o_wb_dest  out  BITS_REGS  register index written in WB.
- o_wb_write  out  1  WB write enable.
- o_stall_count  out  STAT_BITS  stall-cycle counter (see Optional Feature).

Behaviour:
- Clock and reset: single clock i_clk. i_reset is synchronous and active-high.
- Tracking slots: EX, MEM and WB each hold {valid, dest, wr, ld}.
- Destination decode: dest = i_ctl_reg_dst_rd ? i_rd : i_rt. wr = i_ctl_reg_write & (dest != 0); a register-0 write is never tracked.
- Reset: all slots invalid with wr = 0 and ld = 0. o_fwd_a = o_fwd_b = 00. o_wb_dest = 0, o_wb_write = 0. o_stall = 0. o_stall_count = 0.
- o_stall (combinational):
  - Asserted when i_valid & !i_flush & EX.valid & EX.ld & EX.wr and either (i_uses_rs & i_rs == EX.dest) or (i_uses_rt & i_rt == EX.dest).
  - Exactly one stall cycle per load-use pair: after the bubble the load sits in MEM and forwarding covers it.
- Slot advance (each edge when !i_reset and !i_halt):
  - WB <= MEM, MEM <= EX.
  - EX <= bubble if o_stall, i_flush or !i_valid; otherwise EX <= the decoded ID instruction.
- Forwarding (registered, valid while the instruction is in EX):
  - Computed at the edge the instruction enters EX, against the pre-edge EX slot (becomes MEM) and MEM slot (becomes WB).
  - fwd_a = 01 if EX.valid & EX.wr & EX.dest == i_rs & i_uses_rs.
  - Else fwd_a = 10 if MEM.valid & MEM.wr & MEM.dest == i_rs & i_uses_rs.
  - Else fwd_a = 00.
  - fwd_b is the same rule using i_rt and i_uses_rt.
  - Newest producer wins when both slots match.
  - A bubble entering EX loads 00 into both selects.
- o_wb_dest / o_wb_write are driven directly from the WB slot (latency 3 edges from ID acceptance, plus 1 per stall).
- Simultaneous events:
  - i_flush together with a hazard: flush wins, o_stall = 0, bubble enters EX.
  - i_halt: no slot, fwd or counter update, and o_stall is forced 0. Outputs hold their values.
  - i_reset has priority over i_halt.
- A reset asserted mid-stall clears everything on that edge; no pending stall survives it.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: o_stall_count increments on every edge where o_stall = 1 and !i_halt. It saturates at all-ones and clears on reset.
- Undefined: the counter logic is absent, but the port remains and is tied to 0.

Test Plan:
- Load-use: lw r8 (dst_rd=0, rt=8, mem_read=1) then add rs=8 → o_stall=1 for exactly 1 cycle, EX bubble, then o_fwd_a=10 when add is in EX; o_stall_count=1 with HAZARD_STATS_EN.
- ALU chain: add rd=5 then sub rs=5, rt=5 → no stall, o_fwd_a=01 and o_fwd_b=01 in sub's EX cycle; an independent instruction then one using r5 → fwd=10.
- Register 0 and rt selection: ori rt=0 (dst_rd=0, reg_write=1) then use rs=0 → fwd=00, o_wb_write=0. A write with dst_rd=0, rt=9, rd=3 → o_wb_dest=9 three cycles later.
- Flush over hazard: load r4 in EX, i_flush=1 with ID using rs=4 → o_stall=0, bubble enters EX, fwd=00 next cycle.
- Halt: assert i_halt for 4 cycles mid-sequence → slots, fwd, o_wb_* and o_stall_count unchanged, o_stall=0; the sequence then resumes identically.
- Reset mid-stall: i_reset during a load-use stall → next cycle all outputs 0 and no stall.

Source files
------------

// File: rtl/hazard_dest_scheduler.sv
// Destination-register tracker: EX/MEM/WB slots, load-use stall and registered forwarding selects.
// Optional stall statistics counter enabled with `define HAZARD_STATS_EN.
module hazard_dest_scheduler #(
  parameter int BITS_REGS = 5,
  parameter int STAT_BITS = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_halt,
  input  logic                 i_valid,
  input  logic                 i_flush,
  input  logic [BITS_REGS-1:0] i_rs,
  input  logic [BITS_REGS-1:0] i_rt,
  input  logic [BITS_REGS-1:0] i_rd,
  input  logic                 i_uses_rs,
  input  logic                 i_uses_rt,
  input  logic                 i_ctl_reg_dst_rd,
  input  logic                 i_ctl_reg_write,
  input  logic                 i_ctl_mem_read,
  output logic                 o_stall,
  output logic [1:0]           o_fwd_a,
  output logic [1:0]           o_fwd_b,
  output logic [BITS_REGS-1:0] o_wb_dest,
  output logic                 o_wb_write,
  output logic [STAT_BITS-1:0] o_stall_count
);

  logic [BITS_REGS-1:0] id_dest;
  logic                 id_wr;
  logic                 accept;
  logic                 stall;
  logic [1:0]           fwd_a_nxt;
  logic [1:0]           fwd_b_nxt;

  // The load flag is only consulted while the producer sits in EX, so MEM/WB drop it.
  logic                 ex_valid, ex_wr, ex_ld;
  logic [BITS_REGS-1:0] ex_dest;
  logic                 mem_valid, mem_wr;
  logic [BITS_REGS-1:0] mem_dest;
  logic                 wb_valid, wb_wr;
  logic [BITS_REGS-1:0] wb_dest;
  logic [1:0]           fwd_a_q, fwd_b_q;

  assign id_dest = i_ctl_reg_dst_rd ? i_rd : i_rt;
  assign id_wr   = i_ctl_reg_write & (id_dest != '0);

  always_comb begin
    stall = 1'b0;
    if (!i_halt && i_valid && !i_flush && ex_valid && ex_ld && ex_wr) begin
      stall = (i_uses_rs && (i_rs == ex_dest)) || (i_uses_rt && (i_rt == ex_dest));
    end
  end

  assign accept = i_valid & ~i_flush & ~stall;

  always_comb begin
    fwd_a_nxt = 2'b00;
    fwd_b_nxt = 2'b00;
    if (accept && i_uses_rs) begin
      if (ex_valid && ex_wr && (ex_dest == i_rs))
        fwd_a_nxt = 2'b01;
      else if (mem_valid && mem_wr && (mem_dest == i_rs))
        fwd_a_nxt = 2'b10;
    end
    if (accept && i_uses_rt) begin
      if (ex_valid && ex_wr && (ex_dest == i_rt))
        fwd_b_nxt = 2'b01;
      else if (mem_valid && mem_wr && (mem_dest == i_rt))
        fwd_b_nxt = 2'b10;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ex_valid  <= 1'b0;
      ex_wr     <= 1'b0;
      ex_ld     <= 1'b0;
      ex_dest   <= '0;
      mem_valid <= 1'b0;
      mem_wr    <= 1'b0;
      mem_dest  <= '0;
      wb_valid  <= 1'b0;
      wb_wr     <= 1'b0;
      wb_dest   <= '0;
      fwd_a_q   <= 2'b00;
      fwd_b_q   <= 2'b00;
    end else if (!i_halt) begin
      wb_valid  <= mem_valid;
      wb_wr     <= mem_wr;
      wb_dest   <= mem_dest;
      mem_valid <= ex_valid;
      mem_wr    <= ex_wr;
      mem_dest  <= ex_dest;
      if (accept) begin
        ex_valid <= 1'b1;
        ex_wr    <= id_wr;
        ex_ld    <= i_ctl_mem_read;
        ex_dest  <= id_dest;
      end else begin
        ex_valid <= 1'b0;
        ex_wr    <= 1'b0;
        ex_ld    <= 1'b0;
        ex_dest  <= '0;
      end
      fwd_a_q <= fwd_a_nxt;
      fwd_b_q <= fwd_b_nxt;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_BITS-1:0] stall_count_q;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      stall_count_q <= '0;
    else if (stall && (stall_count_q != '1))
      stall_count_q <= stall_count_q + STAT_BITS'(1);
  end

  assign o_stall_count = stall_count_q;
`else
  assign o_stall_count = '0;
`endif

  assign o_stall    = stall;
  assign o_fwd_a    = fwd_a_q;
  assign o_fwd_b    = fwd_b_q;
  assign o_wb_dest  = wb_dest;
  assign o_wb_write = wb_valid & wb_wr;

endmodule

// File: tb/tb_hazard_dest_scheduler.sv
// Directed bench for hazard_dest_scheduler; inputs change 1 time unit after the rising edge.
module tb_hazard_dest_scheduler;

`ifdef HAZARD_STATS_EN
  localparam int SE = 1;
`else
  localparam int SE = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halt = 1'b0;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic        uses_rs = 1'b0, uses_rt = 1'b0;
  logic        dst_rd = 1'b0, reg_write = 1'b0, mem_read = 1'b0;
  logic        stall;
  logic [1:0]  fwd_a, fwd_b;
  logic [4:0]  wb_dest;
  logic        wb_write;
  logic [31:0] stall_count;

  int vecs = 0;
  int errs = 0;

  hazard_dest_scheduler #(.BITS_REGS(5), .STAT_BITS(32)) dut (
    .i_clk(clk), .i_reset(reset), .i_halt(halt), .i_valid(valid), .i_flush(flush),
    .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_uses_rs(uses_rs), .i_uses_rt(uses_rt),
    .i_ctl_reg_dst_rd(dst_rd), .i_ctl_reg_write(reg_write), .i_ctl_mem_read(mem_read),
    .o_stall(stall), .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_wb_dest(wb_dest),
    .o_wb_write(wb_write), .o_stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic fl, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic us, input logic ut, input logic dr,
                       input logic rw, input logic mr);
    valid = v; flush = fl; rs = s; rt = t; rd = d; uses_rs = us; uses_rt = ut;
    dst_rd = dr; reg_write = rw; mem_read = mr;
    #1;
  endtask

  task automatic nops(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    nops(2);
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL rst_stall got=%b exp=0", stall); end
    vecs++; if (fwd_a !== 2'b00) begin errs++; $display("FAIL rst_fwd_a got=%b exp=00", fwd_a); end
    vecs++; if (fwd_b !== 2'b00) begin errs++; $display("FAIL rst_fwd_b got=%b exp=00", fwd_b); end
    vecs++; if (wb_dest !== 5'd0) begin errs++; $display("FAIL rst_wb_dest got=%0d exp=0", wb_dest); end
    vecs++; if (wb_write !== 1'b0) begin errs++; $display("FAIL rst_wb_write got=%b exp=0", wb_write); end
    vecs++; if (stall_count !== 32'd0) begin errs++; $display("FAIL rst_count got=%0d exp=0", stall_count); end
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    drive(1, 0, 2, 8, 0, 1, 0, 0, 1, 1);            // lw r8
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL lu_lw_stall got=%b exp=0", stall); end
    tick();
    drive(1, 0, 8, 3, 10, 1, 1, 1, 1, 0);           // add r10, r8, r3
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL lu_stall got=%b exp=1", stall); end
    tick();
    vecs++; if (fwd_a !== 2'b00) begin errs++; $display("FAIL lu_bubble_fwd_a got=%b exp=00", fwd_a); end
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL lu_stall_once got=%b exp=0", stall); end
    vecs++; if (stall_count !== 32'(SE)) begin errs++; $display("FAIL lu_count got=%0d exp=%0d", stall_count, SE); end
    tick();
    vecs++; if (fwd_a !== 2'b10) begin errs++; $display("FAIL lu_fwd_a got=%b exp=10", fwd_a); end
    vecs++; if (fwd_b !== 2'b00) begin errs++; $display("FAIL lu_fwd_b got=%b exp=00", fwd_b); end
    vecs++; if (wb_dest !== 5'd8) begin errs++; $display("FAIL lu_wb_dest got=%0d exp=8", wb_dest); end
    vecs++; if (wb_write !== 1'b1) begin errs++; $display("FAIL lu_wb_write got=%b exp=1", wb_write); end
  endtask

  task automatic test_alu_chain();
    nops(3);
    drive(1, 0, 1, 2, 5, 1, 1, 1, 1, 0);            // add r5
    tick();
    drive(1, 0, 5, 5, 6, 1, 1, 1, 1, 0);            // sub r6, r5, r5
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL alu_stall got=%b exp=0", stall); end
    tick();
    vecs++; if (fwd_a !== 2'b01) begin errs++; $display("FAIL alu_sub_fwd_a got=%b exp=01", fwd_a); end
    vecs++; if (fwd_b !== 2'b01) begin errs++; $display("FAIL alu_sub_fwd_b got=%b exp=01", fwd_b); end
    drive(1, 0, 5, 6, 11, 1, 1, 1, 1, 0);           // and r11, r5, r6
    tick();
    vecs++; if (fwd_a !== 2'b10) begin errs++; $display("FAIL alu_and_fwd_a got=%b exp=10", fwd_a); end
    vecs++; if (fwd_b !== 2'b01) begin errs++; $display("FAIL alu_and_fwd_b got=%b exp=01", fwd_b); end
    vecs++; if (wb_dest !== 5'd5 || wb_write !== 1'b1) begin
      errs++; $display("FAIL alu_wb got=%0d/%b exp=5/1", wb_dest, wb_write);
    end
  endtask

  task automatic test_newest_wins();
    nops(3);
    drive(1, 0, 1, 2, 5, 0, 0, 1, 1, 0);            // add r5
    tick();
    drive(1, 0, 1, 2, 5, 1, 0, 1, 1, 0);            // or r5
    tick();
    drive(1, 0, 5, 9, 12, 1, 0, 1, 1, 0);           // uses r5, rt not read
    tick();
    vecs++; if (fwd_a !== 2'b01) begin errs++; $display("FAIL nw_fwd_a got=%b exp=01", fwd_a); end
    vecs++; if (fwd_b !== 2'b00) begin errs++; $display("FAIL nw_fwd_b got=%b exp=00", fwd_b); end
  endtask

  task automatic test_reg0_rt();
    nops(3);
    drive(1, 0, 1, 0, 4, 1, 0, 0, 1, 0);            // ori r0
    tick();
    drive(1, 0, 0, 0, 12, 1, 1, 1, 1, 0);           // reads r0
    tick();
    vecs++; if (fwd_a !== 2'b00) begin errs++; $display("FAIL r0_fwd_a got=%b exp=00", fwd_a); end
    vecs++; if (fwd_b !== 2'b00) begin errs++; $display("FAIL r0_fwd_b got=%b exp=00", fwd_b); end
    nops(1);
    vecs++; if (wb_write !== 1'b0) begin errs++; $display("FAIL r0_wb_write got=%b exp=0", wb_write); end
    drive(1, 0, 1, 9, 3, 0, 0, 0, 1, 0);            // dest selects rt=9
    tick();
    nops(2);
    vecs++; if (wb_dest !== 5'd9) begin errs++; $display("FAIL rt_wb_dest got=%0d exp=9", wb_dest); end
    vecs++; if (wb_write !== 1'b1) begin errs++; $display("FAIL rt_wb_write got=%b exp=1", wb_write); end
  endtask

  task automatic test_flush_hazard();
    nops(3);
    drive(1, 0, 1, 4, 0, 0, 0, 0, 1, 1);            // lw r4
    tick();
    drive(1, 1, 4, 2, 4, 1, 0, 1, 1, 0);            // flushed, would write r4
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL fl_stall got=%b exp=0", stall); end
    tick();
    vecs++; if (fwd_a !== 2'b00) begin errs++; $display("FAIL fl_fwd_a got=%b exp=00", fwd_a); end
    drive(1, 0, 4, 2, 7, 1, 0, 1, 1, 0);
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL fl_after_stall got=%b exp=0", stall); end
    tick();
    vecs++; if (fwd_a !== 2'b10) begin errs++; $display("FAIL fl_after_fwd_a got=%b exp=10", fwd_a); end
    vecs++; if (stall_count !== 32'(SE)) begin errs++; $display("FAIL fl_count got=%0d exp=%0d", stall_count, SE); end
  endtask

  task automatic test_halt();
    nops(3);
    drive(1, 0, 1, 2, 15, 0, 0, 1, 1, 0);           // or r15
    tick();
    drive(1, 0, 1, 2, 13, 0, 0, 1, 1, 0);           // add r13
    tick();
    drive(1, 0, 13, 14, 0, 1, 0, 0, 1, 1);          // lw r14, 0(r13)
    tick();
    drive(1, 0, 14, 2, 16, 1, 0, 1, 1, 0);          // uses r14
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL h_pre_stall got=%b exp=1", stall); end
    halt = 1'b1;
    #1;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL h_stall_forced got=%b exp=0", stall); end
    for (int i = 0; i < 4; i++) begin
      tick();
      vecs++; if (wb_dest !== 5'd15 || wb_write !== 1'b1) begin
        errs++; $display("FAIL h_wb[%0d] got=%0d/%b exp=15/1", i, wb_dest, wb_write);
      end
      vecs++; if (fwd_a !== 2'b01) begin errs++; $display("FAIL h_fwd_a[%0d] got=%b exp=01", i, fwd_a); end
      vecs++; if (stall_count !== 32'(SE) || stall !== 1'b0) begin
        errs++; $display("FAIL h_count[%0d] got=%0d/%b exp=%0d/0", i, stall_count, stall, SE);
      end
    end
    halt = 1'b0;
    #1;
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL h_resume_stall got=%b exp=1", stall); end
    tick();
    vecs++; if (fwd_a !== 2'b00) begin errs++; $display("FAIL h_bubble_fwd got=%b exp=00", fwd_a); end
    vecs++; if (wb_dest !== 5'd13) begin errs++; $display("FAIL h_wb13 got=%0d exp=13", wb_dest); end
    vecs++; if (stall_count !== 32'(2 * SE)) begin errs++; $display("FAIL h_count2 got=%0d exp=%0d", stall_count, 2 * SE); end
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL h_stall_once got=%b exp=0", stall); end
    tick();
    vecs++; if (fwd_a !== 2'b10) begin errs++; $display("FAIL h_fwd_a10 got=%b exp=10", fwd_a); end
    vecs++; if (wb_dest !== 5'd14 || wb_write !== 1'b1) begin
      errs++; $display("FAIL h_wb14 got=%0d/%b exp=14/1", wb_dest, wb_write);
    end
  endtask

  task automatic test_reset_mid_stall();
    nops(3);
    drive(1, 0, 1, 20, 0, 0, 0, 0, 1, 1);           // lw r20
    tick();
    drive(1, 0, 20, 2, 21, 1, 0, 1, 1, 0);
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL rs_pre_stall got=%b exp=1", stall); end
    reset = 1'b1;
    tick();
    vecs++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      errs++; $display("FAIL rs_fwd got=%b/%b exp=00/00", fwd_a, fwd_b);
    end
    vecs++; if (wb_dest !== 5'd0 || wb_write !== 1'b0) begin
      errs++; $display("FAIL rs_wb got=%0d/%b exp=0/0", wb_dest, wb_write);
    end
    vecs++; if (stall_count !== 32'd0) begin errs++; $display("FAIL rs_count got=%0d exp=0", stall_count); end
    reset = 1'b0;
    #1;
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL rs_stall got=%b exp=0", stall); end
    tick();
    vecs++; if (fwd_a !== 2'b00) begin errs++; $display("FAIL rs_fwd_after got=%b exp=00", fwd_a); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_chain();
    test_newest_wins();
    test_reg0_rt();
    test_flush_hazard();
    test_halt();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
